// File: rtl/alarm_timer_pkg.sv
// Shared types and constants for the alarm interval timer and its parameter block.
package alarm_timer_pkg;

  localparam int unsigned INTV_W = 2;
  localparam int unsigned DLY_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COUNT   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [INTV_W-1:0] INTV_ARM       = 2'b00;
  localparam logic [INTV_W-1:0] INTV_DRIVER    = 2'b01;
  localparam logic [INTV_W-1:0] INTV_PASSENGER = 2'b10;
  localparam logic [INTV_W-1:0] INTV_ALARM     = 2'b11;

  localparam logic [DLY_W-1:0] DLY_ARM       = 4'd6;
  localparam logic [DLY_W-1:0] DLY_DRIVER    = 4'd8;
  localparam logic [DLY_W-1:0] DLY_PASSENGER = 4'd15;
  localparam logic [DLY_W-1:0] DLY_ALARM     = 4'd10;

  // Factory delay for an interval code, as the parameter block resets to.
  function automatic logic [DLY_W-1:0] default_delay(input logic [INTV_W-1:0] intv);
    logic [DLY_W-1:0] d;
    d = DLY_ARM;
    case (intv)
      INTV_ARM:       d = DLY_ARM;
      INTV_DRIVER:    d = DLY_DRIVER;
      INTV_PASSENGER: d = DLY_PASSENGER;
      INTV_ALARM:     d = DLY_ALARM;
      default:        d = DLY_ARM;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..CLK_FREQ_HZ-1 while enabled, clear has priority.
module sec_prescaler #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap_c
);

  localparam logic [PRESC_W-1:0] CNT_MAX = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [PRESC_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PRESC_W'(1);
      end
    end
  end

  assign o_wrap_c = i_en && !i_clr && (r_cnt == CNT_MAX);

endmodule

// File: rtl/alarm_interval_timer.sv
// Countdown timer for the car-alarm FSM: selects an interval, loads its delay, counts whole seconds.
// Optional TIMER_PAUSE_EN adds a pause input that freezes the countdown while in COUNT.
module alarm_interval_timer
  import alarm_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startTimer,
  input  logic [INTV_W-1:0] intervalSel,
  input  logic [DLY_W-1:0]  value,
  output logic [INTV_W-1:0] interval,
  output logic              expired,
  output logic              busy,
  output logic [DLY_W-1:0]  remaining,
  output logic              secTick
`ifdef TIMER_PAUSE_EN
  ,
  input  logic              pause
`endif
);

  timer_state_t      r_state;
  timer_state_t      w_state_nxt;
  logic [INTV_W-1:0] r_interval;
  logic [INTV_W-1:0] w_interval_nxt;
  logic [DLY_W-1:0]  r_remaining;
  logic [DLY_W-1:0]  w_remaining_nxt;
  logic              r_expired;
  logic              w_expired_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_sec_tick;
  logic              w_sec_tick_nxt;
  logic              w_pause;
  logic              w_presc_clr;
  logic              w_presc_en;
  logic              w_wrap;

`ifdef TIMER_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Prescaler only runs in COUNT; a restart request zeroes it so the first second is full.
  assign w_presc_clr = (r_state != COUNT) || startTimer;
  assign w_presc_en  = (r_state == COUNT) && !w_pause;

  sec_prescaler #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .PRESC_W     (PRESC_W)
  ) u_sec_prescaler (
    .clk      (clk),
    .resetN   (resetN),
    .i_clr    (w_presc_clr),
    .i_en     (w_presc_en),
    .o_wrap_c (w_wrap)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_interval  <= INTV_ARM;
      r_remaining <= '0;
      r_expired   <= 1'b0;
      r_busy      <= 1'b0;
      r_sec_tick  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_interval  <= w_interval_nxt;
      r_remaining <= w_remaining_nxt;
      r_expired   <= w_expired_nxt;
      r_busy      <= w_busy_nxt;
      r_sec_tick  <= w_sec_tick_nxt;
    end
  end

  // Next-state and next-output logic; a start request always wins over countdown events.
  always_comb begin
    w_state_nxt     = r_state;
    w_interval_nxt  = r_interval;
    w_remaining_nxt = r_remaining;
    w_expired_nxt   = 1'b0;
    w_sec_tick_nxt  = 1'b0;
    w_busy_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        if (startTimer) begin
          w_interval_nxt = intervalSel;
          w_state_nxt    = LOAD;
        end
      end
      LOAD: begin
        if (startTimer) begin
          w_interval_nxt = intervalSel;
          w_state_nxt    = LOAD;
        end else begin
          w_remaining_nxt = value;
          if (value == '0) begin
            w_state_nxt   = EXPIRED;
            w_expired_nxt = 1'b1;
          end else begin
            w_state_nxt = COUNT;
          end
        end
      end
      COUNT: begin
        if (startTimer) begin
          w_interval_nxt = intervalSel;
          w_state_nxt    = LOAD;
        end else if (w_wrap) begin
          w_sec_tick_nxt = 1'b1;
          if (r_remaining <= DLY_W'(1)) begin
            w_remaining_nxt = '0;
            w_state_nxt     = EXPIRED;
            w_expired_nxt   = 1'b1;
          end else begin
            w_remaining_nxt = r_remaining - DLY_W'(1);
          end
        end
      end
      EXPIRED: begin
        if (startTimer) begin
          w_interval_nxt = intervalSel;
          w_state_nxt    = LOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == COUNT);
  end

  assign interval  = r_interval;
  assign expired   = r_expired;
  assign busy      = r_busy;
  assign remaining = r_remaining;
  assign secTick   = r_sec_tick;

endmodule

// File: tb/tb_alarm_interval_timer.sv
// Directed bench for alarm_interval_timer at CLK_FREQ_HZ=4 with a behavioural parameter block.
module tb_alarm_interval_timer;

  localparam int unsigned CLK_FREQ_HZ = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startTimer;
  logic [1:0] intervalSel;
  logic [3:0] value;
  logic [1:0] interval;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       secTick;
  logic       pause;
  logic [3:0] arm_dly;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Parameter block: arm delay is programmable, others at factory values.
  always_comb begin
    case (interval)
      2'b00:   value = arm_dly;
      2'b01:   value = 4'd8;
      2'b10:   value = 4'd15;
      default: value = 4'd10;
    endcase
  end

  alarm_interval_timer #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startTimer  (startTimer),
    .intervalSel (intervalSel),
    .value       (value),
    .interval    (interval),
    .expired     (expired),
    .busy        (busy),
    .remaining   (remaining),
    .secTick     (secTick)
`ifdef TIMER_PAUSE_EN
    ,
    .pause       (pause)
`endif
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] arm;
    int         restart_at;
    logic [1:0] rsel;
    int         reprog_at;
    logic [3:0] arm2;
    int         exp_edge;
    int         ticks;
    int         rem_at;
    logic [3:0] rem_val;
  } scn_t;

  scn_t scns [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " interval"}, int'(interval), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " expired"}, int'(expired), 0);
    chk({tag, " remaining"}, int'(remaining), 0);
    chk({tag, " secTick"}, int'(secTick), 0);
  endtask

  // Edge counts n are measured from the edge E0 that samples the start request.
  task automatic run_scn(input int idx, input scn_t s);
    int tick_cnt;
    int exp_cnt;
    int exp_at;
    tick_cnt = 0;
    exp_cnt  = 0;
    exp_at   = -1;
    arm_dly     = s.arm;
    intervalSel = s.sel;
    startTimer  = 1'b1;
    step();
    startTimer = 1'b0;
    chk($sformatf("s%0d interval", idx), int'(interval), int'(s.sel));
    chk($sformatf("s%0d busy_load", idx), int'(busy), 1);
    for (int n = 1; n <= 60; n++) begin
      if (n == s.restart_at) begin
        startTimer  = 1'b1;
        intervalSel = s.rsel;
      end
      if (n == s.reprog_at) arm_dly = s.arm2;
      step();
      startTimer = 1'b0;
      if (n == s.restart_at)
        chk($sformatf("s%0d interval_restart", idx), int'(interval), int'(s.rsel));
      if (n == s.rem_at)
        chk($sformatf("s%0d remaining_load", idx), int'(remaining), int'(s.rem_val));
      if (n == s.exp_edge - 1)
        chk($sformatf("s%0d busy_before", idx), int'(busy), 1);
      if (n == s.exp_edge)
        chk($sformatf("s%0d busy_at_expire", idx), int'(busy), 0);
      if (secTick) tick_cnt++;
      if (expired) begin
        exp_cnt++;
        if (exp_at < 0) exp_at = n;
      end
    end
    chk($sformatf("s%0d expire_edge", idx), exp_at, s.exp_edge);
    chk($sformatf("s%0d expire_count", idx), exp_cnt, 1);
    if (s.ticks >= 0)
      chk($sformatf("s%0d ticks", idx), tick_cnt, s.ticks);
    chk($sformatf("s%0d remaining_end", idx), int'(remaining), 0);
    chk($sformatf("s%0d busy_end", idx), int'(busy), 0);
  endtask

  initial begin
    int exp_cnt;
    int busy_cnt;

    //            sel    arm   rst rsel   rpg arm2  exp  tk  remat rem
    scns[0] = '{2'b00, 4'd6,  0, 2'b00, 0, 4'd0, 25,  6,  1, 4'd6};
    scns[1] = '{2'b10, 4'd6, 10, 2'b01, 0, 4'd0, 43, 10, 11, 4'd8};
    scns[2] = '{2'b00, 4'd0,  0, 2'b00, 0, 4'd0,  1,  0,  1, 4'd0};
    scns[3] = '{2'b11, 4'd6,  0, 2'b00, 0, 4'd0, 41, 10,  1, 4'd10};
    scns[4] = '{2'b01, 4'd6,  0, 2'b00, 0, 4'd0, 33,  8,  1, 4'd8};
    scns[5] = '{2'b00, 4'd1,  5, 2'b00, 0, 4'd0, 10, -1,  6, 4'd1};
    scns[6] = '{2'b00, 4'd3,  0, 2'b00, 3, 4'd0, 13,  3,  1, 4'd3};

    resetN      = 1'b0;
    startTimer  = 1'b0;
    intervalSel = 2'b11;
    pause       = 1'b0;
    arm_dly     = 4'd6;
    #12;
    chk_idle("in_reset");
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_idle($sformatf("idle%0d", i));
    end

    for (int k = 0; k < 7; k++) run_scn(k, scns[k]);

    // Asynchronous reset mid-count while remaining=3.
    arm_dly     = 4'd6;
    intervalSel = 2'b01;
    startTimer  = 1'b1;
    step();
    startTimer = 1'b0;
    for (int n = 1; n <= 21; n++) step();
    chk("rst_mid remaining_before", int'(remaining), 3);
    chk("rst_mid secTick_before", int'(secTick), 1);
    #2;
    resetN = 1'b0;
    #1;
    chk_idle("rst_mid async");
    @(negedge clk);
    resetN = 1'b1;
    exp_cnt  = 0;
    busy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (expired) exp_cnt++;
      if (busy) busy_cnt++;
    end
    chk("rst_mid expired_after", exp_cnt, 0);
    chk("rst_mid busy_after", busy_cnt, 0);

`ifdef TIMER_PAUSE_EN
    begin
      int exp_at;
      int pause_ticks;
      exp_at      = -1;
      pause_ticks = 0;
      intervalSel = 2'b11;
      startTimer  = 1'b1;
      step();
      startTimer = 1'b0;
      for (int n = 1; n <= 60; n++) begin
        pause = (n >= 7 && n <= 15);
        step();
        if (pause && secTick) pause_ticks++;
        if (expired && exp_at < 0) exp_at = n;
      end
      pause = 1'b0;
      chk("pause expire_edge", exp_at, 50);
      chk("pause ticks_while_paused", pause_ticks, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
